// File: rtl/imm_gen_pkg.sv
// Shared immediate-select codes and the instruction-to-immediate extension function.
// IMMGEN_SELCHK_EN widens the select code to 4 bits so that codes 8-15 are illegal and can be flagged.
package imm_gen_pkg;

`ifdef IMMGEN_SELCHK_EN
    localparam int IMMSEL_W = 4;
`else
    localparam int IMMSEL_W = 3;
`endif

    localparam logic [IMMSEL_W-1:0] IMMSEL_I    = IMMSEL_W'(0);
    localparam logic [IMMSEL_W-1:0] IMMSEL_S    = IMMSEL_W'(1);
    localparam logic [IMMSEL_W-1:0] IMMSEL_B    = IMMSEL_W'(2);
    localparam logic [IMMSEL_W-1:0] IMMSEL_J    = IMMSEL_W'(3);
    localparam logic [IMMSEL_W-1:0] IMMSEL_U    = IMMSEL_W'(4);
    localparam logic [IMMSEL_W-1:0] IMMSEL_Z    = IMMSEL_W'(5);
    localparam logic [IMMSEL_W-1:0] IMMSEL_SH   = IMMSEL_W'(6);
    localparam logic [IMMSEL_W-1:0] IMMSEL_NONE = IMMSEL_W'(7);

`ifdef IMMGEN_SELCHK_EN
    function automatic logic imm_sel_legal(input logic [IMMSEL_W-1:0] sel);
        return sel <= IMMSEL_NONE;
    endfunction
`endif

    // inst holds instruction bits [31:7], so instruction bit b lives at inst[b-7].
    // The result is 64 bits wide; callers keep the low XLEN bits.
    function automatic logic [63:0] imm_extend(input logic [24:0] inst,
                                               input logic [IMMSEL_W-1:0] sel,
                                               input logic xlen64);
        logic [63:0] r;
        r = '0;
        case (sel)
            IMMSEL_I:  r = {{52{inst[24]}}, inst[24:13]};
            IMMSEL_S:  r = {{52{inst[24]}}, inst[24:18], inst[4:0]};
            IMMSEL_B:  r = {{51{inst[24]}}, inst[24], inst[0], inst[23:18], inst[4:1], 1'b0};
            IMMSEL_J:  r = {{43{inst[24]}}, inst[24], inst[12:5], inst[13], inst[23:14], 1'b0};
            IMMSEL_U:  r = {{32{inst[24]}}, inst[24:5], 12'b0};
            IMMSEL_Z:  r = {59'b0, inst[12:8]};
            IMMSEL_SH: r = {58'b0, xlen64 & inst[18], inst[17:13]};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_gen_fifo.sv
// Generic DEPTH x W in-order buffer with wrapping head/tail pointers, occupancy count and flush.
// Read data is forced to zero whenever the buffer is empty.
module imm_gen_fifo
    import imm_gen_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [W-1:0] wr_data,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready is a pure function of occupancy, so a pop never opens a same-cycle slot.
    assign wr_ready = (count != FULL);
    assign rd_valid = (count != '0);
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = rd_valid ? mem[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[tail] <= wr_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Buffered decode-stage immediate generator: extends on entry, queues {tag, imm} in order.
// Defining IMMGEN_SELCHK_EN adds err_o (per-entry illegal select) and err_sticky_o.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [24:0]         inst_i,
    input  logic [IMMSEL_W-1:0] imm_sel_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     imm_o,
    output logic [TAG_W-1:0]    tag_o
`ifdef IMMGEN_SELCHK_EN
    ,
    output logic                err_o,
    output logic                err_sticky_o
`endif
);

    // Handshake: a word transfers on a cycle where valid and ready are both high;
    // valid must hold with stable data until taken, and ready never depends on the other side's valid.

`ifdef IMMGEN_SELCHK_EN
    localparam int ENTRY_W = XLEN + TAG_W + 1;
`else
    localparam int ENTRY_W = XLEN + TAG_W;
`endif

    logic [63:0]        imm_full;
    logic [XLEN-1:0]    imm_ext;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    assign imm_full = imm_extend(inst_i, imm_sel_i, XLEN == 64);
    assign imm_ext  = imm_full[XLEN-1:0];

    generate
        if (XLEN < 64) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^imm_full[63:XLEN];
        end
    endgenerate

`ifdef IMMGEN_SELCHK_EN
    assign wr_entry = {~imm_sel_legal(imm_sel_i), tag_i, imm_ext};
    assign err_o    = rd_entry[ENTRY_W-1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                 err_sticky_o <= 1'b0;
        else if (out_valid_o && err_o) err_sticky_o <= 1'b1;
    end
`else
    assign wr_entry = {tag_i, imm_ext};
`endif

    imm_gen_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .flush    (flush_i),
        .wr_valid (in_valid_i),
        .wr_ready (in_ready_o),
        .wr_data  (wr_entry),
        .rd_valid (out_valid_o),
        .rd_ready (out_ready_i),
        .rd_data  (rd_entry)
    );

    assign imm_o = rd_entry[XLEN-1:0];
    assign tag_o = rd_entry[XLEN +: TAG_W];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: queue-based reference model plus directed literal cases.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int TAG_W = 8;
    localparam int EW    = 1 + TAG_W + XLEN;
`ifdef IMMGEN_SELCHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                flush = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [31:0]         inst_w = '0;
    logic [IMMSEL_W-1:0] sel = '0;
    logic [TAG_W-1:0]    tag = '0;
    logic                in_ready;
    logic                out_valid;
    logic [XLEN-1:0]     imm;
    logic [TAG_W-1:0]    tag_out;
`ifdef IMMGEN_SELCHK_EN
    logic                err;
    logic                err_sticky;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [EW-1:0]    exp_q[$];
    logic [TAG_W-1:0] popped_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .inst_i      (inst_w[31:7]),
        .imm_sel_i   (sel),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .imm_o       (imm),
        .tag_o       (tag_out)
`ifdef IMMGEN_SELCHK_EN
        ,
        .err_o        (err),
        .err_sticky_o (err_sticky)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx(input logic [63:0] v, input int n);
        longint s;
        s = longint'(v) <<< (64 - n);
        return 64'(s >>> (64 - n));
    endfunction

    function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w, input int s);
        logic [63:0] r;
        case (s)
            0: r = sx(64'(w[31:20]), 12);
            1: r = sx(64'({w[31:25], w[11:7]}), 12);
            2: r = sx(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
            3: r = sx(64'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
            4: r = sx(64'(w) & 64'hFFFF_F000, 32);
            5: r = 64'((w >> 15) & 32'h1F);
            6: r = 64'((w >> 20) & 32'(XLEN - 1));
            default: r = '0;
        endcase
        return r[XLEN-1:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic do_push;
        logic do_pop;
        logic e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (flush) begin
            exp_q.delete();
        end else begin
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = (exp_q.size() > 0) && out_ready;
            e = CHK && (int'(sel) > 7);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({e, tag, ref_imm(inst_w, int'(sel))});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs must match the head of the model queue.
    always @(negedge clk) begin
        logic [EW-1:0] h;
        h = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
        check("imm", 64'(imm), 64'(h[XLEN-1:0]));
        check("tag", 64'(tag_out), 64'(h[XLEN +: TAG_W]));
`ifdef IMMGEN_SELCHK_EN
        check("err", 64'(err), 64'(h[EW-1]));
`endif
        if (out_valid && out_ready) popped_q.push_back(tag_out);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input int s, input logic [TAG_W-1:0] t);
        in_valid = v;
        inst_w   = w;
        sel      = IMMSEL_W'(s);
        tag      = t;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            step();
            k++;
        end
        if (k >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: timeout, in_ready stuck at 0");
        end
    endtask

    task automatic fmt_case(input string name, input logic [31:0] w, input int s, input logic [63:0] e);
        check({"model_", name}, 64'(ref_imm(w, s)), 64'(e[XLEN-1:0]));
        step();
        drive(1'b1, w, s, 8'hA5);
        step();
        drive(1'b0, 32'h0, 0, 8'h00);
        @(negedge clk);
        check({"fmt_", name}, 64'(imm), 64'(e[XLEN-1:0]));
        check({"fmt_valid_", name}, 64'(out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset state
        repeat (3) step();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imm", 64'(imm), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        rst_n = 1'b1;
        step();

        // formats, one cycle latency each
        out_ready = 1'b1;
        fmt_case("I_neg", 32'hFFF00093, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        fmt_case("I_pos", 32'h7FF00093, 0, 64'h0000_0000_0000_07FF);
        fmt_case("S",     32'hFE112E23, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        fmt_case("B",     32'hFE000CE3, 2, 64'hFFFF_FFFF_FFFF_FFF8);
        fmt_case("J",     32'h001000EF, 3, 64'h0000_0000_0000_0800);
        fmt_case("U",     32'h123450B7, 4, 64'h0000_0000_1234_5000);
        fmt_case("U_neg", 32'h800000B7, 4, 64'hFFFF_FFFF_8000_0000);
        fmt_case("Z",     32'h000F8073, 5, 64'h0000_0000_0000_001F);
        fmt_case("SH",    32'h03F00013, 6, (XLEN == 64) ? 64'h3F : 64'h1F);
        fmt_case("NONE",  32'hFFF00093, 7, 64'h0);
        step();

        // backpressure: two stored, third held until space opens
        out_ready = 1'b0;
        popped_q.delete();
        drive(1'b1, $urandom, $urandom_range(0, 6), 8'd1);
        step();
        drive(1'b1, $urandom, $urandom_range(0, 6), 8'd2);
        step();
        drive(1'b1, $urandom, $urandom_range(0, 6), 8'd3);
        step();
        step();
        check("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        wait_ready();
        step();
        drive(1'b0, 32'h0, 0, 8'h00);
        repeat (4) step();
        check("bp_count", 64'(popped_q.size()), 64'd3);
        for (int i = 0; i < 3 && i < popped_q.size(); i++)
            check("bp_order", 64'(popped_q[i]), 64'(i + 1));

        // streaming: one word per cycle after one cycle of latency
        popped_q.delete();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, $urandom_range(0, 7), 8'(i + 16));
            step();
        end
        drive(1'b0, 32'h0, 0, 8'h00);
        check("stream_latency", 64'(popped_q.size()), 64'd15);
        repeat (3) step();
        check("stream_count", 64'(popped_q.size()), 64'd16);
        for (int i = 0; i < 16 && i < popped_q.size(); i++)
            check("stream_order", 64'(popped_q[i]), 64'(i + 16));

        // flush with buffer full plus a push attempt
        out_ready = 1'b0;
        drive(1'b1, $urandom, 0, 8'd40);
        step();
        drive(1'b1, $urandom, 0, 8'd41);
        step();
        drive(1'b1, $urandom, 0, 8'd42);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 0, 8'h00);
        @(negedge clk);
        check("flush_full_valid", 64'(out_valid), 64'd0);
        check("flush_full_ready", 64'(in_ready), 64'd1);

        // flush with one entry plus an acceptable push: the push is discarded
        popped_q.delete();
        step();
        drive(1'b1, $urandom, 0, 8'd50);
        step();
        drive(1'b1, $urandom, 0, 8'd51);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 0, 8'h00);
        @(negedge clk);
        check("flush_one_valid", 64'(out_valid), 64'd0);
        step();
        out_ready = 1'b1;
        drive(1'b1, $urandom, 0, 8'd52);
        step();
        drive(1'b0, 32'h0, 0, 8'h00);
        repeat (3) step();
        check("flush_after_count", 64'(popped_q.size()), 64'd1);
        if (popped_q.size() > 0) check("flush_after_tag", 64'(popped_q[0]), 64'd52);

`ifdef IMMGEN_SELCHK_EN
        // illegal select: flagged, zero immediate, sticky until reset
        drive(1'b1, 32'hFFF00093, 9, 8'd77);
        step();
        drive(1'b0, 32'h0, 0, 8'h00);
        @(negedge clk);
        check("selchk_err", 64'(err), 64'd1);
        check("selchk_imm", 64'(imm), 64'd0);
        repeat (3) step();
        check("selchk_sticky", 64'(err_sticky), 64'd1);
`endif

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, (1 << IMMSEL_W) - 1),
                  TAG_W'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        drive(1'b0, 32'h0, 0, 8'h00);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        drive(1'b1, $urandom, 0, 8'd60);
        step();
        drive(1'b1, $urandom, 1, 8'd61);
        step();
        drive(1'b0, 32'h0, 0, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_imm", 64'(imm), 64'd0);
        check("arst_tag", 64'(tag_out), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("arst_ready", 64'(in_ready), 64'd1);
`ifdef IMMGEN_SELCHK_EN
        check("arst_sticky", 64'(err_sticky), 64'd0);
`endif
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
